// File: rtl/freq_result_uart_tx.sv
// -----------------------------------------------------------------------------
// freq_result_uart_tx
//
// Consumes one result from the frequency counter and sends it to the MCU as a
// 10-byte UART 8N1 frame:
//   HEADER, clk_num[31:24..7:0], sig_num[31:24..7:0], checksum
// The checksum is the XOR of the 8 data bytes; HEADER is not included.
//
// Handshake with the counter:
//   - out_valid (from the sig_in domain) is synchronised by two flops (ov_s).
//   - Once ov_s is seen, m_gdata_ready drops. This freezes the counter and
//     clears it, so clk_num/sig_num hold still while they are latched.
//   - After the frame, the block waits for out_valid to fall before it
//     re-raises m_gdata_ready. This gives exactly one frame per result.
//
// Ports:
//   clk_in_100MHz  in   system clock; the only clock
//   rst_n          in   asynchronous active-low reset
//   clk_num[31:0]  in   reference-clock count; stable while out_valid = 1
//   sig_num[31:0]  in   signal-edge count; stable while out_valid = 1
//   out_valid      in   result valid; asynchronous to clk_in_100MHz
//   m_gdata_ready  out  1 = counter may run (registered)
//   uart_tx        out  UART TX line, idle high (registered)
//   busy           out  high whenever the FSM is not IDLE (registered)
//   frame_done     out  one-cycle pulse after the last stop bit (registered)
// -----------------------------------------------------------------------------
module freq_result_uart_tx #(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk_in_100MHz,
  input  logic        rst_n,
  input  logic [31:0] clk_num,
  input  logic [31:0] sig_num,
  input  logic        out_valid,
  output logic        m_gdata_ready,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned          CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           LAST_BIT  = 4'd9;  // stop bit index
  localparam logic [3:0]           LAST_DATA = 4'd8;  // last data bit index
  localparam logic [3:0]           LAST_BYTE = 4'd9;  // checksum byte index
  localparam int unsigned          N_BYTES   = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    SEND     = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic             ov_meta_q;
  logic             ov_s_q;
  state_t           state_q,    state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_idx_q,  bit_idx_d;   // 0 = start, 1..8 = data, 9 = stop
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       shift_q,    shift_d;     // current byte, LSB goes out next
  logic [7:0]       frame_q [N_BYTES];
  logic [7:0]       frame_d [N_BYTES];
  logic             tx_q,       tx_d;
  logic             ready_q,    ready_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  // ---------------------------------------------------------------------------
  // Frame assembly from the live counter outputs
  // ---------------------------------------------------------------------------
  logic [63:0] result_bits;
  logic [7:0]  cap_bytes [N_BYTES];
  logic [7:0]  cap_sum;
  logic [3:0]  next_byte_idx;

  assign result_bits = {clk_num, sig_num};
  assign cap_bytes[0] = HEADER;
  assign cap_bytes[N_BYTES-1] = cap_sum;

  // Data bytes go MSB first: clk_num high byte lands at index 1.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_data_bytes
      assign cap_bytes[gi+1] = result_bits[63-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    cap_sum = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      cap_sum = cap_sum ^ cap_bytes[i];
    end
  end

  assign next_byte_idx = byte_idx_q + 4'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Level triggered, so a result that is already valid at reset
        // release is still picked up.
        if (ov_s_q) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Ready is already low here, so the counter is frozen. The start bit
        // of the header begins on this edge.
        frame_d    = cap_bytes;
        state_d    = SEND;
        baud_cnt_d = '0;
        bit_idx_d  = 4'd0;
        byte_idx_d = 4'd0;
        shift_d    = HEADER;
        tx_d       = 1'b0;
      end

      SEND: begin
        if (baud_cnt_q == CNT_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            if (byte_idx_q == LAST_BYTE) begin
              state_d    = WAIT_CLR;
              done_d     = 1'b1;
              tx_d       = 1'b1;
              bit_idx_d  = 4'd0;
              byte_idx_d = 4'd0;
            end else begin
              // The next start bit follows the stop bit directly, with no idle gap.
              byte_idx_d = next_byte_idx;
              bit_idx_d  = 4'd0;
              shift_d    = frame_q[next_byte_idx];
              tx_d       = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == LAST_DATA) begin
              tx_d = 1'b1;
            end else begin
              tx_d    = shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
            end
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      WAIT_CLR: begin
        tx_d = 1'b1;
        if (!ov_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Outputs are decoded from the next state. This lets them change on the
    // same edge as the state they describe.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ov_meta_q  <= 1'b0;
      ov_s_q     <= 1'b0;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 4'd0;
      byte_idx_q <= 4'd0;
      shift_q    <= 8'h00;
      for (int i = 0; i < N_BYTES; i++) begin
        frame_q[i] <= 8'h00;
      end
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ov_meta_q  <= out_valid;
      ov_s_q     <= ov_meta_q;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign m_gdata_ready = ready_q;
  assign uart_tx       = tx_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_freq_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_freq_result_uart_tx
//
// Scoreboard bench. Each stimulus pushes its hand-computed frame bytes into
// exp_q. An independent UART monitor decodes uart_tx at negedges, pops the
// queue and compares. It also checks that every bit lasts 10 clocks and that
// frame_done fires 1000 clocks after the first start bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_result_uart_tx;

  localparam int CPB = 10;

  logic        clk_in_100MHz;
  logic        rst_n;
  logic [31:0] clk_num;
  logic [31:0] sig_num;
  logic        out_valid;
  logic        m_gdata_ready;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int epoch = 0;
  int frames_seen = 0;
  logic [7:0] exp_q [$];

  freq_result_uart_tx #(
    .CLK_FREQ(100),
    .BAUD(10),
    .HEADER(8'hA5)
  ) dut (
    .clk_in_100MHz(clk_in_100MHz),
    .rst_n(rst_n),
    .clk_num(clk_num),
    .sig_num(sig_num),
    .out_valid(out_valid),
    .m_gdata_ready(m_gdata_ready),
    .uart_tx(uart_tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial clk_in_100MHz = 1'b0;
  always #5 clk_in_100MHz = ~clk_in_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [79:0] f);
    for (int i = 0; i < 10; i++) exp_q.push_back(f[79-8*i -: 8]);
  endtask

  // Raise out_valid and measure how many edges pass before ready drops.
  task automatic issue(input string name, input logic [31:0] c, input logic [31:0] s);
    int n;
    @(negedge clk_in_100MHz);
    clk_num   = c;
    sig_num   = s;
    out_valid = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk_in_100MHz); #1;
      n++;
      if (!m_gdata_ready) break;
    end
    check({name, "_ready_latency_le3"}, 32'(n <= 3 && !m_gdata_ready), 32'd1);
    $display("issue %s clk_num=%08h sig_num=%08h ready_fall_edges=%0d", name, c, s, n);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk_in_100MHz); #1;
      n++;
      if (frame_done) break;
    end
    check({name, "_frame_done_seen"}, 32'(frame_done), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: UART decoder and scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int ep;
    bit aborted;
    logic smp [10];
    logic [7:0] d;
    int bad;
    logic [7:0] e;
    forever begin
      @(negedge clk_in_100MHz);
      if (rst_n && uart_tx === 1'b0) begin
        ep = epoch;
        aborted = 0;
        for (int by = 0; by < 10; by++) begin
          d = 8'h00;
          bad = 0;
          for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < CPB; j++) begin
              if (!(by == 0 && b == 0 && j == 0)) @(negedge clk_in_100MHz);
              if (epoch != ep) aborted = 1;
              smp[j] = uart_tx;
            end
            if (aborted) break;
            for (int j = 0; j < CPB; j++) if (smp[j] !== smp[5]) bad++;
            if (b == 0 && smp[5] !== 1'b0) bad++;
            if (b == 9 && smp[5] !== 1'b1) bad++;
            if (b >= 1 && b <= 8) d[b-1] = smp[5];
          end
          if (aborted) break;
          check($sformatf("byte%0d_bit_timing", by), 32'(bad), 32'd0);
          if (exp_q.size() == 0) begin
            check($sformatf("byte%0d_unexpected", by), {24'h0, d}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d_data", by), {24'h0, d}, {24'h0, e});
          end
          $display("rx byte %0d = %02h", by, d);
        end
        if (!aborted) begin
          @(negedge clk_in_100MHz);
          check("frame_done_at_1000", 32'(frame_done), 32'd1);
          frames_seen++;
          $display("rx frame complete, frames_seen=%0d", frames_seen);
        end else begin
          $display("rx frame abandoned by reset");
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int f0;
    int n;
    int hi_cnt;
    rst_n     = 1'b0;
    clk_num   = 32'h0;
    sig_num   = 32'h0;
    out_valid = 1'b0;
    repeat (3) @(posedge clk_in_100MHz);
    #1;
    check("reset_ready", 32'(m_gdata_ready), 32'd1);
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk_in_100MHz);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_in_100MHz);

    // Nominal frame with a pulsed out_valid.
    f0 = frames_seen;
    push_frame(80'hA5_00_01_86_A0_00_00_00_64_43);
    issue("nominal", 32'h000186A0, 32'h00000064);
    repeat (5) @(posedge clk_in_100MHz);
    #1 check("nominal_busy", 32'(busy), 32'd1);
    out_valid = 1'b0;
    wait_done("nominal");
    @(negedge clk_in_100MHz); #1;
    check("nominal_frames", 32'(frames_seen), 32'(f0 + 1));
    n = 0;
    while (n < 10 && !m_gdata_ready) begin
      @(posedge clk_in_100MHz); #1; n++;
    end
    check("nominal_ready_back", 32'(m_gdata_ready), 32'd1);

    // Held out_valid, with clk_num changing mid-frame.
    repeat (10) @(posedge clk_in_100MHz);
    f0 = frames_seen;
    push_frame(80'hA5_00_01_86_A0_00_00_00_64_43);
    issue("held", 32'h000186A0, 32'h00000064);
    repeat (300) @(posedge clk_in_100MHz);
    #2 clk_num = 32'hFFFFFFFF;
    wait_done("held");
    hi_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_in_100MHz); #1;
      if (m_gdata_ready) hi_cnt++;
    end
    check("held_ready_stays_low", 32'(hi_cnt), 32'd0);
    check("held_single_frame", 32'(frames_seen), 32'(f0 + 1));
    check("held_busy", 32'(busy), 32'd1);
    @(negedge clk_in_100MHz);
    out_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk_in_100MHz); #1; n++;
      if (m_gdata_ready) break;
    end
    check("held_ready_after_drop_2to3", 32'(m_gdata_ready && n >= 2 && n <= 3), 32'd1);
    $display("held: ready returned %0d edges after out_valid fell", n);

    // Reset during byte 4.
    repeat (10) @(posedge clk_in_100MHz);
    push_frame(80'hA5_00_01_86_A0_00_00_00_64_43);
    issue("rstmid", 32'h000186A0, 32'h00000064);
    @(negedge clk_in_100MHz);
    out_valid = 1'b0;
    n = 0;
    while (n < 20 && uart_tx) begin
      @(posedge clk_in_100MHz); #1; n++;
    end
    check("rstmid_start_seen", 32'(uart_tx), 32'd0);
    repeat (450) @(posedge clk_in_100MHz);
    #2;
    rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    #1;
    check("rstmid_tx", 32'(uart_tx), 32'd1);
    check("rstmid_ready", 32'(m_gdata_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk_in_100MHz);
    @(negedge clk_in_100MHz);
    rst_n = 1'b1;
    repeat (200) @(posedge clk_in_100MHz);
    f0 = frames_seen;
    push_frame(80'hA5_00_01_86_A0_00_00_00_64_43);
    issue("after_rst", 32'h000186A0, 32'h00000064);
    @(negedge clk_in_100MHz);
    out_valid = 1'b0;
    wait_done("after_rst");
    @(negedge clk_in_100MHz); #1;
    check("after_rst_frames", 32'(frames_seen), 32'(f0 + 1));

    // All-ones result.
    repeat (10) @(posedge clk_in_100MHz);
    push_frame(80'hA5_FF_FF_FF_FF_FF_FF_FF_FF_00);
    issue("ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk_in_100MHz);
    out_valid = 1'b0;
    wait_done("ones");
    repeat (10) @(posedge clk_in_100MHz);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

endmodule

// File: doc/freq_result_uart_tx.md
Name: freq_result_uart_tx

Overview:
- MCU-side consumer of the frequency counter's result handshake.
- Watches out_valid and captures clk_num/sig_num when it is high.
- Drives m_gdata_ready low to freeze and clear the counter, then serialises the result to the MCU as a 10-byte UART 8N1 frame.
- Re-arms the counter once out_valid has dropped.
- Sits between the counter outputs and the board UART pin; replaces the MCU polling parallel buses.

Parameters:
- CLK_FREQ, 100000000: clk_in_100MHz frequency in Hz.
- BAUD, 115200: UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 868 at defaults): clocks per UART bit; must be >= 2.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk_in_100MHz  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_num  in  32  reference-clock count from the counter; stable while out_valid = 1.
- sig_num  in  32  signal-edge count from the counter; stable while out_valid = 1.
- out_valid  in  1  result valid, generated in the sig_in domain; asynchronous to clk_in_100MHz.
- m_gdata_ready  out  1  ready to the counter; 1 = counter may run.
- uart_tx  out  1  UART TX line; idle high.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (async, rst_n = 0):
  - m_gdata_ready = 1, uart_tx = 1, busy = 0, frame_done = 0.
  - state = IDLE; all counters and shift registers = 0.
  - Sync flops = 0.
- Synchronisation: out_valid passes a 2-flop synchroniser giving ov_s. No other signal crosses a domain.
  - clk_num/sig_num are sampled directly; they are safe because the counter holds them constant while out_valid = 1, and ov_s lags by >= 2 cycles.
- States: IDLE, CAPTURE, SEND, WAIT_CLR.
- IDLE:
  - m_gdata_ready = 1.
  - Level-triggered: when ov_s = 1, go to CAPTURE.
  - out_valid high at reset release is therefore captured.
- CAPTURE (one cycle):
  - Latch the 10-byte frame buffer: HEADER, clk_num[31:24], [23:16], [15:8], [7:0], sig_num[31:24], [23:16], [15:8], [7:0], checksum.
  - Checksum = XOR of the 8 data bytes (HEADER excluded).
  - m_gdata_ready goes 0 from this edge (registered output).
  - Next state is SEND, byte index 0.
- Ready-deassert latency: at most 3 clk_in_100MHz edges after out_valid is sampled high.
- SEND:
  - Per byte: start bit (0), 8 data bits LSB first, stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles; bit timer counts 0..CLKS_PER_BIT-1.
  - Bytes are sent back-to-back with no idle gap.
  - Frame length = 100 bit times.
  - After the stop bit of byte 9: frame_done = 1 for one cycle; go to WAIT_CLR.
  - m_gdata_ready stays 0 throughout SEND.
  - Changes on clk_num/sig_num/out_valid during SEND are ignored.
- WAIT_CLR:
  - m_gdata_ready = 0; uart_tx = 1.
  - Stay until ov_s = 0, then go to IDLE, where m_gdata_ready = 1 is registered on the next edge.
  - Guarantees exactly one frame per result, even if out_valid is slow to drop (it clears only on a sig_in edge). With a stalled sig_in the block waits indefinitely.
- Simultaneous events:
  - ov_s rising in the same cycle the block enters IDLE from WAIT_CLR is handled next cycle.
  - No result is lost; the counter cannot produce a new one while ready = 0.
- Reset mid-frame:
  - uart_tx returns high immediately (async); the partial frame is abandoned.
  - Ready = 1; no frame_done.
- Widths:
  - Bit timer is clog2(CLKS_PER_BIT) bits; bit index 4 bits; byte index 4 bits.
  - No arithmetic overflow is possible.

Test Plan:
- Nominal frame:
  - Stimulus: CLK_FREQ = 100, BAUD = 10 (CLKS_PER_BIT = 10); clk_num = 32'h000186A0, sig_num = 32'h00000064; pulse out_valid high.
  - Required: ready falls within 3 clocks; uart_tx decodes A5 00 01 86 A0 00 00 00 64 43; frame_done after exactly 1000 clocks from the start bit.
- Bit timing:
  - Measure every uart_tx bit of the frame above.
  - Required: each bit is 10 clocks; start bit 0, stop bit 1; no inter-byte gap.
- Held out_valid:
  - Keep out_valid = 1 for 5000 cycles after the frame.
  - Required: a single frame only; ready stays 0 until 2-3 cycles after out_valid falls, then 1.
- Data changing during SEND:
  - Change clk_num to 32'hFFFFFFFF mid-frame.
  - Required: the transmitted bytes still carry 000186A0 with checksum 43.
- Reset mid-frame:
  - Assert rst_n = 0 during byte 4.
  - Required: uart_tx = 1, ready = 1, busy = 0 immediately; out_valid re-asserted after reset produces a complete new frame.
- All-ones result:
  - clk_num = sig_num = 32'hFFFFFFFF.
  - Required: bytes A5, FF×8, checksum 00.
